// File: rtl/cio_uart_bridge.sv
// Console bridge between the DekatronPC character I/O handshake and an 8N1 UART.
// BCD cells are converted to bytes for transmit; received bytes come back as BCD.
module cio_uart_bridge #(
    parameter int DATA_DEKATRON_NUM = 3,
    parameter int DEKATRON_WIDTH    = 4,
    parameter int CLK_DIV           = 16
) (
    input  logic                                        Clk,
    input  logic                                        Rst_n,
    input  logic                                        Cout,
    input  logic                                        CinReq,
    input  logic [DATA_DEKATRON_NUM*DEKATRON_WIDTH-1:0] Data,
    output logic                                        CioAcq,
    output logic [DATA_DEKATRON_NUM*DEKATRON_WIDTH-1:0] DataCin,
    output logic                                        Txd,
    input  logic                                        Rxd,
    output logic                                        RxOverrun
);

    localparam int N  = DATA_DEKATRON_NUM;
    localparam int DW = DEKATRON_WIDTH;
    localparam int W  = N * DW;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, TX_BUSY, ACK_HOLD} state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Horner evaluation; truncating intermediates keeps the result mod 256.
    function automatic logic [7:0] bcd_to_byte(input logic [W-1:0] d);
        logic [15:0] acc;
        acc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            acc = 16'(acc * 16'd10) + 16'(d[i*DW +: DW]);
        end
        return acc[7:0];
    endfunction

    function automatic logic [W-1:0] byte_to_bcd(input logic [7:0] b);
        logic [W-1:0] r;
        logic [7:0]   v;
        r = '0;
        v = b;
        for (int i = 0; i < N; i++) begin
            r[i*DW +: DW] = DW'(v % 8'd10);
            v             = v / 8'd10;
        end
        return r;
    endfunction

    state_e          state_q;
    logic            ack_q;
    logic [W-1:0]    data_cin_q;
    logic [7:0]      tx_byte_q;
    logic            tx_start_q;

    logic            tx_busy_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [3:0]      tx_bit_q;
    logic [8:0]      tx_frame_q;
    logic            txd_q;

    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e       rx_state_q;
    logic [CW-1:0]   rx_cnt_q;
    logic [2:0]      rx_bit_q;
    logic [7:0]      rx_shift_q;

    logic [7:0]      buf_q;
    logic            buf_full_q;
    logic            overrun_q;

    logic [7:0]      tx_byte_d;
    logic [W-1:0]    data_cin_d;
    logic            tx_done_w;
    logic            rx_valid_w;
    logic            buf_take_w;

    assign tx_byte_d  = bcd_to_byte(Data);
    assign data_cin_d = byte_to_bcd(buf_q);
    assign tx_done_w  = tx_busy_q && (tx_cnt_q == DIV_LAST) && (tx_bit_q == 4'd9);
    assign rx_valid_w = (rx_state_q == RX_STOP) && (rx_cnt_q == DIV_LAST) && rx_s2_q;
    assign buf_take_w = (state_q == IDLE) && !Cout && CinReq && buf_full_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            data_cin_q <= '0;
            tx_byte_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Cout) begin
                        tx_byte_q  <= tx_byte_d;
                        tx_start_q <= 1'b1;
                        state_q    <= TX_BUSY;
                    end else if (CinReq && buf_full_q) begin
                        data_cin_q <= data_cin_d;
                        ack_q      <= 1'b1;
                        state_q    <= ACK_HOLD;
                    end
                end
                TX_BUSY: begin
                    if (tx_done_w) begin
                        ack_q   <= 1'b1;
                        state_q <= ACK_HOLD;
                    end
                end
                ACK_HOLD: begin
                    if (!Cout && !CinReq) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Start bit goes out on load; the stop bit sits in tx_frame_q[8].
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= '1;
            txd_q      <= 1'b1;
        end else if (tx_start_q) begin
            tx_busy_q  <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_frame_q <= {1'b1, tx_byte_q};
            txd_q      <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == DIV_LAST) begin
                tx_cnt_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                end else begin
                    txd_q      <= tx_frame_q[0];
                    tx_frame_q <= {1'b1, tx_frame_q[8:1]};
                    tx_bit_q   <= tx_bit_q + 4'd1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q   <= Rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_s2_q && rx_prev_q) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        // A line already back high at mid-bit was a glitch.
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == DIV_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == DIV_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // A byte landing in the same cycle as a delivery replaces the delivered one.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (rx_valid_w) begin
            if (buf_full_q && !buf_take_w) begin
                overrun_q <= 1'b1;
            end else begin
                buf_q      <= rx_shift_q;
                buf_full_q <= 1'b1;
            end
        end else if (buf_take_w) begin
            buf_full_q <= 1'b0;
        end
    end

    assign CioAcq    = ack_q;
    assign DataCin   = data_cin_q;
    assign Txd       = txd_q;
    assign RxOverrun = overrun_q;

endmodule
